axi_lite_slave_regs: RTL and testbench

AXI_LITE_SLAVE_REGS -- requirements
Module: axi_lite_slave_regs

---
 rtl/axi_lite_slave_regs.sv | 158 +++++++++++++++
 tb/tb_axi_lite_slave_regs.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit byte-strobed registers.
// Independent write (W_IDLE/W_RESP) and read (R_IDLE/R_DATA) FSMs; all outputs registered.
module axi_lite_slave_regs #(
  parameter int          NUM_REGS  = 4,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] AWADDR,
  input  logic [2:0]  AWPROT,
  input  logic        WVALID,
  output logic        WREADY,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  output logic        BVALID,
  input  logic        BREADY,
  output logic [1:0]  BRESP,
  input  logic        ARVALID,
  output logic        ARREADY,
  input  logic [31:0] ARADDR,
  input  logic [2:0]  ARPROT,
  output logic        RVALID,
  input  logic        RREADY,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP
);

  localparam int          IW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * NUM_REGS);
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [1:0]  RESP_SLV   = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [31:0] regs [NUM_REGS];

  w_state_t    w_state;
  logic        aw_held, w_held;
  logic [31:0] aw_addr_q, w_data_q;
  logic [3:0]  w_strb_q;

  logic          aw_hs, w_hs, wr_in_range;
  logic [31:0]   wr_addr, wr_data;
  logic [3:0]    wr_strb;
  logic [IW-1:0] wr_idx;

  r_state_t      r_state;
  logic          ar_in_range;
  logic [IW-1:0] ar_idx;

  logic unused_prot;
  assign unused_prot = ^{AWPROT, ARPROT};

  // A beat arriving on the completing edge is used directly; an earlier beat comes from the hold regs.
  always_comb begin
    aw_hs       = AWVALID && AWREADY;
    w_hs        = WVALID && WREADY;
    wr_addr     = aw_hs ? AWADDR : aw_addr_q;
    wr_data     = w_hs ? WDATA : w_data_q;
    wr_strb     = w_hs ? WSTRB : w_strb_q;
    wr_in_range = (wr_addr < ADDR_LIMIT);
    wr_idx      = wr_addr[IW+1:2];
    ar_in_range = (ARADDR < ADDR_LIMIT);
    ar_idx      = ARADDR[IW+1:2];
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state   <= W_IDLE;
      AWREADY   <= 1'b0;
      WREADY    <= 1'b0;
      BVALID    <= 1'b0;
      BRESP     <= RESP_OKAY;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      case (w_state)
        W_IDLE: begin
          if ((aw_held || aw_hs) && (w_held || w_hs)) begin
            if (wr_in_range) begin
              for (int b = 0; b < 4; b++)
                if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
            BRESP   <= wr_in_range ? RESP_OKAY : RESP_SLV;
            BVALID  <= 1'b1;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            w_state <= W_RESP;
          end else begin
            if (aw_hs) begin
              aw_held   <= 1'b1;
              aw_addr_q <= AWADDR;
            end
            if (w_hs) begin
              w_held   <= 1'b1;
              w_data_q <= WDATA;
              w_strb_q <= WSTRB;
            end
            AWREADY <= !(aw_held || aw_hs);
            WREADY  <= !(w_held || w_hs);
          end
        end
        W_RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            AWREADY <= 1'b1;
            WREADY  <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Sampling regs with <= yields the pre-write value when a write lands on the same edge.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RDATA   <= '0;
      RRESP   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ARVALID && ARREADY) begin
            RVALID  <= 1'b1;
            ARREADY <= 1'b0;
            RDATA   <= ar_in_range ? regs[ar_idx] : 32'h0;
            RRESP   <= ar_in_range ? RESP_OKAY : RESP_SLV;
            r_state <= R_DATA;
          end else begin
            ARREADY <= 1'b1;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            RVALID  <= 1'b0;
            ARREADY <= 1'b1;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Directed scoreboard bench for axi_lite_slave_regs (NUM_REGS=4, non-zero RESET_VAL).
module tb_axi_lite_slave_regs;
  localparam int          NR   = 4;
  localparam logic [31:0] RVAL = 32'h5A5A_1234;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        AWVALID = 1'b0, AWREADY;
  logic [31:0] AWADDR = '0;
  logic [2:0]  AWPROT = 3'b010;
  logic        WVALID = 1'b0, WREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        BVALID, BREADY = 1'b0;
  logic [1:0]  BRESP;
  logic        ARVALID = 1'b0, ARREADY;
  logic [31:0] ARADDR = '0;
  logic [2:0]  ARPROT = 3'b001;
  logic        RVALID, RREADY = 1'b0;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;

  axi_lite_slave_regs #(.NUM_REGS(NR), .RESET_VAL(RVAL)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
  );

  always #5 ACLK = ~ACLK;

  int          checks = 0;
  int          passed = 0;
  logic [31:0] model [NR];
  logic [1:0]  bq [$];
  logic [33:0] rq [$];

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) model[i] = RVAL;
  endtask

  // Updates the model and queues the expected BRESP before driving the bus.
  task automatic expect_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    if (addr < 32'(4 * NR)) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[int'(addr[5:2])][8*b +: 8] = data[8*b +: 8];
      bq.push_back(2'b00);
    end else begin
      bq.push_back(2'b10);
    end
  endtask

  task automatic expect_read(input logic [31:0] addr);
    if (addr < 32'(4 * NR)) rq.push_back({2'b00, model[int'(addr[5:2])]});
    else                    rq.push_back({2'b10, 32'h0});
  endtask

  // w_start/aw_start: cycle on which each channel raises VALID; bhold<0 leaves BVALID pending.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int w_start, input int aw_start, input int bhold);
    logic aw_done, w_done, aw_hs, w_hs;
    logic [1:0] er;
    int c;
    aw_done = 1'b0; w_done = 1'b0; c = 0;
    expect_write(addr, data, strb);
    while (!(aw_done && w_done) && c < 40) begin
      AWVALID = !aw_done && (c >= aw_start);
      AWADDR  = addr;
      WVALID  = !w_done && (c >= w_start);
      WDATA   = data;
      WSTRB   = strb;
      aw_hs   = AWVALID && AWREADY;
      w_hs    = WVALID && WREADY;
      tick();
      aw_done = aw_done | aw_hs;
      w_done  = w_done | w_hs;
      c++;
    end
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    check("wr_handshakes", {30'b0, aw_done, w_done}, 32'h3);
    check("bvalid_next_cycle", BVALID, 1);
    er = bq.pop_front();
    check("bresp", BRESP, er);
    if (bhold < 0) return;
    for (int i = 0; i < bhold; i++) begin
      tick();
      check("bvalid_hold", BVALID, 1);
      check("bresp_hold", BRESP, er);
      check("awready_wready_low", {AWREADY, WREADY}, 0);
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    check("bvalid_drop", BVALID, 0);
    check("awready_wready_back", {AWREADY, WREADY}, 32'h3);
  endtask

  task automatic do_read(input logic [31:0] addr, input int rhold);
    logic done, hs;
    logic [33:0] e;
    int c;
    done = 1'b0; c = 0;
    expect_read(addr);
    ARADDR = addr;
    while (!done && c < 20) begin
      ARVALID = 1'b1;
      hs = ARVALID && ARREADY;
      tick();
      done = hs;
      c++;
    end
    ARVALID = 1'b0;
    check("ar_handshake", done, 1);
    check("rvalid_next_cycle", RVALID, 1);
    e = rq.pop_front();
    check("rdata", RDATA, e[31:0]);
    check("rresp", RRESP, e[33:32]);
    for (int i = 0; i < rhold; i++) begin
      tick();
      check("rvalid_hold", RVALID, 1);
      check("rdata_hold", RDATA, e[31:0]);
      check("rresp_hold", RRESP, e[33:32]);
      check("arready_low", ARREADY, 0);
    end
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    check("rvalid_drop", RVALID, 0);
    check("arready_back", ARREADY, 1);
  endtask

  initial begin
    logic [1:0]  er;
    logic [33:0] e;
    model_reset();

    // Reset state
    tick(); tick();
    check("rst_readies", {AWREADY, WREADY, ARREADY}, 0);
    check("rst_valids", {BVALID, RVALID}, 0);
    check("rst_resps", {BRESP, RRESP}, 0);
    check("rst_rdata", RDATA, 0);
    ARESET = 1'b0;
    check("readies_low_before_edge", {AWREADY, WREADY, ARREADY}, 0);
    tick();
    check("readies_first_edge", {AWREADY, WREADY, ARREADY}, 32'h7);
    for (int i = 0; i < NR; i++) do_read(32'(4 * i), 0);

    // Same-cycle AW+W, then read back
    do_write(32'h4, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    do_read(32'h4, 0);

    // W leads AW by three cycles, partial strobes over zero
    do_write(32'h8, 32'h0, 4'hF, 0, 0, 0);
    do_write(32'h8, 32'h1122_3344, 4'b0101, 0, 3, 0);
    do_read(32'h8, 0);

    // AW leads W, low address bits ignored
    do_write(32'hE, 32'h89AB_CDEF, 4'b1010, 2, 0, 0);
    do_read(32'hF, 0);

    // Out-of-range write and reads
    do_write(32'h10, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    for (int i = 0; i < NR; i++) do_read(32'(4 * i), 0);
    do_read(32'h10, 0);
    do_read(32'h100, 0);

    // Zero strobes
    do_write(32'h4, 32'h0, 4'h0, 0, 0, 0);
    do_read(32'h4, 0);

    // Response backpressure
    do_write(32'h0, 32'h1357_2468, 4'hF, 0, 0, 5);
    do_read(32'h0, 5);

    // AR and register update on the same edge return the pre-write value
    expect_read(32'h4);
    expect_write(32'h4, 32'h0BAD_F00D, 4'hF);
    AWADDR = 32'h4; WDATA = 32'h0BAD_F00D; WSTRB = 4'hF; ARADDR = 32'h4;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    er = bq.pop_front();
    e  = rq.pop_front();
    check("conc_bvalid", BVALID, 1);
    check("conc_bresp", BRESP, er);
    check("conc_rvalid", RVALID, 1);
    check("conc_rdata_old", RDATA, e[31:0]);
    check("conc_rresp", RRESP, e[33:32]);
    BREADY = 1'b1; RREADY = 1'b1;
    tick();
    BREADY = 1'b0; RREADY = 1'b0;
    do_read(32'h4, 0);

    // Reset while a write response is pending
    do_write(32'hC, 32'hCAFE_F00D, 4'hF, 0, 0, -1);
    #2 ARESET = 1'b1;
    #1;
    check("arst_bvalid", BVALID, 0);
    check("arst_readies", {AWREADY, WREADY, ARREADY}, 0);
    check("arst_rdata", RDATA, 0);
    model_reset();
    tick();
    ARESET = 1'b0;
    tick();
    check("post_rst_readies", {AWREADY, WREADY, ARREADY}, 32'h7);
    for (int i = 0; i < NR; i++) do_read(32'(4 * i), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
